// File: rtl/sdram_port_arb.sv
// Four-client round-robin arbiter in front of one SDRAM controller channel.
// Each client request is latched into a slot and issued to the controller one at a time.
module sdram_port_arb #(
  parameter int NCLI    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               init,
  input  logic [NCLI-1:0]    cli_req,
  input  logic [NCLI-1:0]    cli_rnw,
  input  logic [26*NCLI-1:0] cli_addr,
  input  logic [16*NCLI-1:0] cli_din,
  output logic [16*NCLI-1:0] cli_dout,
  output logic [NCLI-1:0]    cli_ready,
  output logic               mem_req,
  output logic               mem_rnw,
  output logic [25:0]        mem_addr,
  output logic [15:0]        mem_din,
  input  logic [15:0]        mem_dout,
  input  logic               mem_ready,
  output logic [1:0]         grant,
  output logic               busy,
  output logic [NCLI-1:0]    ovf,
  output logic [NCLI-1:0]    tmo,
  output logic [1:0]         dbg_state
);

  // Controller handshake: mem_req is a one-cycle pulse; the access completes on
  // the first mem_ready pulse seen in WAIT, or is aborted after TIMEOUT WAIT cycles.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

  state_t      state, state_nx;
  logic [3:0]  pend;
  logic [3:0]  s_rnw;
  logic [25:0] s_addr [4];
  logic [15:0] s_din  [4];
  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;
  logic        do_issue;
  logic        complete;
  logic        timed_out;
  logic [3:0]  clr_vec;
  logic [1:0]  winner;
  logic [1:0]  idx;
  logic        found;

  assign cnt_inc   = cnt + 8'd1;
  assign clr_vec   = complete ? (4'b0001 << grant) : 4'b0000;
  assign busy      = (state == ISSUE) || (state == WAIT);
  assign dbg_state = state;

  // Search starts just after the last grant, so the previous winner is considered last.
  always_comb begin
    winner = grant;
    found  = 1'b0;
    idx    = grant;
    for (int k = 1; k <= 4; k++) begin
      idx = grant + 2'(k);
      if (!found && pend[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (init) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    do_issue  = 1'b0;
    complete  = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        if (|pend) begin
          do_issue = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (mem_ready) begin
          complete = 1'b1;
          state_nx = IDLE;
        end else if (cnt_inc == TMO_LIM) begin
          complete  = 1'b1;
          timed_out = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A request landing on its own completion cycle refills the slot instead of overflowing.
  always_ff @(posedge clk) begin
    if (init) begin
      pend  <= '0;
      ovf   <= '0;
      s_rnw <= '0;
      for (int i = 0; i < 4; i++) begin
        s_addr[i] <= '0;
        s_din[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cli_req[i]) begin
          if (!pend[i] || clr_vec[i]) begin
            pend[i]   <= 1'b1;
            s_rnw[i]  <= cli_rnw[i];
            s_addr[i] <= cli_addr[26*i +: 26];
            s_din[i]  <= cli_din[16*i +: 16];
          end else begin
            ovf[i] <= 1'b1;
          end
        end else if (clr_vec[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      mem_req   <= 1'b0;
      mem_rnw   <= 1'b1;
      mem_addr  <= '0;
      mem_din   <= '0;
      grant     <= 2'd3;
      cli_ready <= '0;
      cli_dout  <= '0;
      tmo       <= '0;
      cnt       <= '0;
    end else begin
      mem_req   <= do_issue;
      cli_ready <= clr_vec;
      if (do_issue) begin
        grant    <= winner;
        mem_addr <= s_addr[winner];
        mem_din  <= s_din[winner];
        mem_rnw  <= s_rnw[winner];
      end
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt_inc;
      for (int i = 0; i < 4; i++) begin
        if (clr_vec[i] && s_rnw[i])
          cli_dout[16*i +: 16] <= timed_out ? 16'hFFFF : mem_dout;
      end
      if (timed_out) tmo <= tmo | clr_vec;
    end
  end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb: table of single accesses plus hand-written
// sequences for arbitration, overflow, timeout and reset corner cases.
module tb_sdram_port_arb;

  logic         clk = 1'b0;
  logic         init;
  logic [3:0]   cli_req;
  logic [3:0]   cli_rnw;
  logic [103:0] cli_addr;
  logic [63:0]  cli_din;
  logic [63:0]  cli_dout;
  logic [3:0]   cli_ready;
  logic         mem_req;
  logic         mem_rnw;
  logic [25:0]  mem_addr;
  logic [15:0]  mem_din;
  logic [15:0]  mem_dout;
  logic         mem_ready;
  logic [1:0]   grant;
  logic         busy;
  logic [3:0]   ovf;
  logic [3:0]   tmo;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_dout;

  sdram_port_arb #(.NCLI(4), .TIMEOUT(8)) dut (
    .clk(clk), .init(init), .cli_req(cli_req), .cli_rnw(cli_rnw),
    .cli_addr(cli_addr), .cli_din(cli_din), .cli_dout(cli_dout),
    .cli_ready(cli_ready), .mem_req(mem_req), .mem_rnw(mem_rnw),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_ready(mem_ready), .grant(grant), .busy(busy), .ovf(ovf),
    .tmo(tmo), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    int          cli;
    logic        rnw;
    logic [25:0] addr;
    logic [15:0] din;
    int          lat;
    logic [15:0] rdata;
    logic [15:0] exp_slice;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_req(input int c, input logic rnw, input logic [25:0] addr,
                         input logic [15:0] din);
    cli_req[c]            = 1'b1;
    cli_rnw[c]            = rnw;
    cli_addr[26*c +: 26]  = addr;
    cli_din[16*c +: 16]   = din;
  endtask

  task automatic wait_req();
    for (int n = 0; n < 20 && !mem_req; n++) tick();
    check("mem_req_seen", {63'd0, mem_req}, 64'd1);
  endtask

  // Called in the mem_req cycle; controller model answers lat edges later.
  task automatic serve(input int lat, input logic [15:0] rdata, output logic [3:0] rdy);
    for (int j = 1; j < lat; j++) tick();
    mem_ready = 1'b1;
    mem_dout  = rdata;
    tick();
    mem_ready = 1'b0;
    mem_dout  = 16'h0000;
    rdy = cli_ready;
  endtask

  task automatic do_reset();
    init = 1'b1;
    tick();
    tick();
    init = 1'b0;
    exp_dout = '0;
  endtask

  initial begin
    logic [3:0] rdy;
    int         cnt_req;
    int         cnt_rdy;

    init = 1'b1; cli_req = '0; cli_rnw = '0; cli_addr = '0; cli_din = '0;
    mem_dout = '0; mem_ready = 1'b0; exp_dout = '0;
    tick(); tick(); tick();
    check("rst_mem_req",   {63'd0, mem_req}, 64'd0);
    check("rst_mem_rnw",   {63'd0, mem_rnw}, 64'd1);
    check("rst_mem_addr",  {38'd0, mem_addr}, 64'd0);
    check("rst_grant",     {62'd0, grant}, 64'd3);
    check("rst_busy",      {63'd0, busy}, 64'd0);
    check("rst_cli_ready", {60'd0, cli_ready}, 64'd0);
    check("rst_cli_dout",  cli_dout, 64'd0);
    check("rst_ovf_tmo",   {56'd0, ovf, tmo}, 64'd0);
    init = 1'b0;

    vecs[0] = '{cli: 2, rnw: 1'b1, addr: 26'h0123456, din: 16'h0000, lat: 5, rdata: 16'hBEEF, exp_slice: 16'hBEEF};
    vecs[1] = '{cli: 0, rnw: 1'b0, addr: 26'h3FFFFFF, din: 16'h1234, lat: 2, rdata: 16'hDEAD, exp_slice: 16'h0000};
    vecs[2] = '{cli: 3, rnw: 1'b1, addr: 26'h0000001, din: 16'h0000, lat: 3, rdata: 16'h5A5A, exp_slice: 16'h5A5A};
    vecs[3] = '{cli: 1, rnw: 1'b1, addr: 26'h2AAAAAA, din: 16'h0000, lat: 9, rdata: 16'h0001, exp_slice: 16'h0001};
    vecs[4] = '{cli: 2, rnw: 1'b0, addr: 26'h1555555, din: 16'hCAFE, lat: 4, rdata: 16'h7777, exp_slice: 16'hBEEF};

    for (int v = 0; v < 5; v++) begin
      set_req(vecs[v].cli, vecs[v].rnw, vecs[v].addr, vecs[v].din);
      tick();
      cli_req = '0;
      tick();
      check("vec_mem_req",  {63'd0, mem_req}, 64'd1);
      check("vec_grant",    {62'd0, grant}, 64'(vecs[v].cli));
      check("vec_mem_addr", {38'd0, mem_addr}, {38'd0, vecs[v].addr});
      check("vec_mem_rnw",  {63'd0, mem_rnw}, {63'd0, vecs[v].rnw});
      check("vec_mem_din",  {48'd0, mem_din}, {48'd0, vecs[v].din});
      check("vec_busy",     {63'd0, busy}, 64'd1);
      serve(vecs[v].lat, vecs[v].rdata, rdy);
      exp_dout[16*vecs[v].cli +: 16] = vecs[v].exp_slice;
      check("vec_cli_ready", {60'd0, rdy}, {60'd0, 4'b0001 << vecs[v].cli});
      check("vec_slice", {48'd0, cli_dout[16*vecs[v].cli +: 16]}, {48'd0, vecs[v].exp_slice});
      check("vec_cli_dout", cli_dout, exp_dout);
      tick();
      check("vec_ready_once", {60'd0, cli_ready}, 64'd0);
      check("vec_idle", {63'd0, busy}, 64'd0);
    end
    check("vec_no_tmo", {60'd0, tmo}, 64'd0);

    // all four clients at once, from reset
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 26'(32'h100 * (i + 1)), 16'(32'h1000 + i));
    tick();
    cli_req = '0;
    for (int k = 0; k < 4; k++) begin
      wait_req();
      check("all_grant",   {62'd0, grant}, 64'(k));
      check("all_mem_din", {48'd0, mem_din}, 64'(32'h1000 + k));
      check("all_mem_rnw", {63'd0, mem_rnw}, 64'd0);
      serve(2, 16'hFFFF, rdy);
      check("all_ready", {60'd0, rdy}, {60'd0, 4'b0001 << k});
    end
    check("all_dout_kept", cli_dout, 64'd0);

    // rotation: client 1 refills on its own completion while client 0 waits
    set_req(1, 1'b1, 26'h0000A1, 16'h0);
    tick();
    cli_req = '0;
    wait_req();
    check("rot_first_grant", {62'd0, grant}, 64'd1);
    tick();
    set_req(0, 1'b1, 26'h0000A0, 16'h0);
    tick();
    cli_req = '0;
    set_req(1, 1'b1, 26'h0000B1, 16'h0);
    mem_ready = 1'b1;
    mem_dout  = 16'h1111;
    tick();
    cli_req = '0;
    mem_ready = 1'b0;
    exp_dout[31:16] = 16'h1111;
    check("rot_ready1", {60'd0, cli_ready}, 64'b0010);
    check("rot_dout1",  cli_dout, exp_dout);
    wait_req();
    check("rot_grant0", {62'd0, grant}, 64'd0);
    check("rot_addr0",  {38'd0, mem_addr}, 64'h0A0);
    serve(2, 16'h2222, rdy);
    exp_dout[15:0] = 16'h2222;
    check("rot_ready0", {60'd0, rdy}, 64'b0001);
    wait_req();
    check("rot_grant1", {62'd0, grant}, 64'd1);
    check("rot_addr1",  {38'd0, mem_addr}, 64'h0B1);
    serve(3, 16'h3333, rdy);
    exp_dout[31:16] = 16'h3333;
    check("rot_ready1b", {60'd0, rdy}, 64'b0010);
    check("rot_dout",    cli_dout, exp_dout);
    tick();
    check("rot_idle", {62'd0, busy, mem_req}, 64'd0);

    // overflow: second request to a pending slot is dropped
    set_req(3, 1'b0, 26'h0000C3, 16'hAAAA);
    tick();
    set_req(3, 1'b0, 26'h0000D3, 16'hBBBB);
    tick();
    cli_req = '0;
    check("ovf_mem_req", {63'd0, mem_req}, 64'd1);
    check("ovf_grant",   {62'd0, grant}, 64'd3);
    check("ovf_addr",    {38'd0, mem_addr}, 64'h0C3);
    check("ovf_din",     {48'd0, mem_din}, 64'hAAAA);
    check("ovf_flag",    {60'd0, ovf}, 64'b1000);
    serve(3, 16'h0, rdy);
    check("ovf_ready", {60'd0, rdy}, 64'b1000);
    cnt_req = 0;
    cnt_rdy = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      cnt_req += int'(mem_req);
      cnt_rdy += int'(cli_ready[3]);
    end
    check("ovf_no_reissue", 64'(cnt_req), 64'd0);
    check("ovf_one_ready",  64'(cnt_rdy), 64'd0);
    check("ovf_sticky",     {60'd0, ovf}, 64'b1000);

    // timeout on client 0 read, late ready ignored, client 1 served next
    set_req(0, 1'b1, 26'h0000E0, 16'h0);
    set_req(1, 1'b0, 26'h0000E1, 16'h5555);
    tick();
    cli_req = '0;
    wait_req();
    check("tmo_grant", {62'd0, grant}, 64'd0);
    for (int n = 0; n < 8; n++) tick();
    check("tmo_not_early", {60'd0, cli_ready}, 64'd0);
    check("tmo_still_busy", {63'd0, busy}, 64'd1);
    tick();
    exp_dout[15:0] = 16'hFFFF;
    check("tmo_ready", {60'd0, cli_ready}, 64'b0001);
    check("tmo_dout",  cli_dout, exp_dout);
    check("tmo_flag",  {60'd0, tmo}, 64'b0001);
    mem_ready = 1'b1;
    mem_dout  = 16'h9999;
    tick();
    mem_ready = 1'b0;
    check("tmo_late_ignored", {60'd0, cli_ready}, 64'd0);
    check("tmo_next_grant",   {62'd0, grant}, 64'd1);
    check("tmo_next_addr",    {38'd0, mem_addr}, 64'h0E1);
    serve(2, 16'h0, rdy);
    check("tmo_ready1",  {60'd0, rdy}, 64'b0010);
    check("tmo_dout_kept", cli_dout, exp_dout);

    // reset during WAIT
    set_req(2, 1'b1, 26'h0000F2, 16'h0);
    tick();
    cli_req = '0;
    wait_req();
    tick();
    tick();
    check("rw_in_wait", {62'd0, dbg_state}, 64'd2);
    init = 1'b1;
    tick();
    init = 1'b0;
    exp_dout = '0;
    check("rw_busy",    {63'd0, busy}, 64'd0);
    check("rw_grant",   {62'd0, grant}, 64'd3);
    check("rw_flags",   {56'd0, ovf, tmo}, 64'd0);
    check("rw_mem_rnw", {63'd0, mem_rnw}, 64'd1);
    check("rw_dout",    cli_dout, 64'd0);
    check("rw_state",   {62'd0, dbg_state}, 64'd0);
    mem_ready = 1'b1;
    mem_dout  = 16'h7E7E;
    tick();
    mem_ready = 1'b0;
    check("rw_no_ready", {60'd0, cli_ready}, 64'd0);
    tick();
    check("rw_no_pend", {62'd0, mem_req, busy}, 64'd0);
    set_req(0, 1'b1, 26'h0000F0, 16'h0);
    tick();
    cli_req = '0;
    tick();
    check("rw_new_req",   {63'd0, mem_req}, 64'd1);
    check("rw_new_grant", {62'd0, grant}, 64'd0);
    serve(2, 16'h4321, rdy);
    exp_dout[15:0] = 16'h4321;
    check("rw_new_ready", {60'd0, rdy}, 64'b0001);
    check("rw_new_dout",  cli_dout, exp_dout);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
